// File: rtl/shift_rows_stage.sv
// -----------------------------------------------------------------------------
// shift_rows_stage
//
// AES ShiftRows stage with valid/ready flow control on both sides. It sits
// between SubBytes and MixColumns in the encryption datapath. The row rotation
// is applied before a state is stored, so the 2-entry output queue only ever
// holds transformed states. Because the queue has two entries, upstream and
// downstream can stall independently without losing or duplicating a state.
//
// State layout: byte i is bits [127-8i -: 8], stored column-major. Byte 4c+r
// is therefore row r, column c.
//
// Build option:
//   SHIFT_ROWS_INV_EN - when defined, adds the in_inv port. in_inv is sampled
//                       with each push; 1 selects inverse ShiftRows for that
//                       transfer. When undefined, only the forward transform
//                       exists.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous, active-low reset
//   in_valid   in   1    in_data holds a state to transfer
//   in_ready   out  1    stage can accept a state this cycle (registered)
//   in_data    in   128  input state
//   in_inv     in   1    inverse select (SHIFT_ROWS_INV_EN builds only)
//   out_valid  out  1    out_data holds a transformed state
//   out_ready  in   1    downstream accepts out_data this cycle
//   out_data   out  128  transformed state, same byte layout as in_data
// -----------------------------------------------------------------------------
module shift_rows_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef SHIFT_ROWS_INV_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    // Forward: out[r][c] = in[r][(c+r) mod 4]
    // Inverse: out[r][c] = in[r][(c-r) mod 4]
    // The 2-bit cast performs the mod 4, including for negative differences.
    function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                                input logic         inv);
        logic [127:0] res;
        logic [1:0]   src_c;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_c = inv ? 2'(c - r) : 2'(c + r);
                res[127 - 8 * (4 * c + r) -: 8] =
                    s[127 - 8 * (4 * int'(src_c) + r) -: 8];
            end
        end
        return res;
    endfunction

    logic mode_inv;
`ifdef SHIFT_ROWS_INV_EN
    assign mode_inv = in_inv;
`else
    assign mode_inv = 1'b0;
`endif

    logic [127:0] entry [2];
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         push;
    logic         pop;
    logic [127:0] shifted;

    assign shifted   = shift_rows(in_data, mode_inv);
    assign out_valid = (count != 2'd0);
    assign out_data  = entry[head];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: count_next gets a default before the conditional updates, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b0;
            // NOTE: the two storage entries are reset deliberately. out_data
            // must read 0 during and right after reset, and the queue is only
            // 256 bits deep.
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            // in_ready is 0 when the queue is full, so a push can never
            // overwrite a valid entry.
            if (push) begin
                entry[tail] <= shifted;
                tail        <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count    <= count_next;
            // Ready looks only at the registered occupancy. It does not
            // depend combinationally on out_ready.
            in_ready <= (count_next < 2'd2);
        end
    end

endmodule

// File: tb/tb_shift_rows_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_stage
//
// Directed, self-checking bench for shift_rows_stage. Inputs change 1 time unit
// after the rising edge, and outputs are checked at that same offset. Expected
// values come from hand-computed vectors and from a small row/column reference
// model.
// -----------------------------------------------------------------------------
module tb_shift_rows_stage;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    shift_rows_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SHIFT_ROWS_INV_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. The state is unpacked into a row x column matrix, and
    // each output cell is read from the source column of its row.
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inv);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        int           src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127 - 8 * (4 * c + r) -: 8];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127 - 8 * (4 * c + r) -: 8] = m[r][src];
            end
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] VEC_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] VEC_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic [127:0] st_a, st_b, st_c;
    logic [127:0] rnd [16];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;

        // ---------------- reset and first transfer ----------------
        step();
        step();
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_data",  out_data, '0);
        check("rst_in_ready",  128'(in_ready), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ready_after_release", 128'(in_ready), 128'(1'b1));

        in_valid = 1'b1;
        in_data  = VEC_IN;
        step();
        in_valid = 1'b0;
        check("first_out_valid", 128'(out_valid), 128'(1'b1));
        check("first_out_data",  out_data, VEC_OUT);
        out_ready = 1'b1;
        step();
        check("first_drained", 128'(out_valid), 128'(1'b0));

        // ---------------- backpressure ----------------
        st_a = 128'h00112233445566778899aabbccddeeff;
        st_b = 128'h000102030405060708090a0b0c0d0e0f;
        st_c = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = st_a;
        step();
        check("bp_ready_cnt1", 128'(in_ready), 128'(1'b1));
        // Hand-computed ShiftRows of A.
        check("bp_head_a", out_data, 128'h0055aaff4499ee3388dd2277cc1166bb);
        in_data = st_b;
        step();
        check("bp_ready_full", 128'(in_ready), 128'(1'b0));
        in_data = st_c;
        step();
        check("bp_c_held_ready", 128'(in_ready), 128'(1'b0));
        check("bp_stable_1", out_data, ref_shift(st_a, 0));
        step();
        check("bp_stable_2", out_data, ref_shift(st_a, 0));
        check("bp_valid_held", 128'(out_valid), 128'(1'b1));
        // Count 2 with a pop: only the pop happens, and ready returns.
        out_ready = 1'b1;
        step();
        check("bp_out_b", out_data, ref_shift(st_b, 0));
        check("bp_ready_back", 128'(in_ready), 128'(1'b1));
        // Count 1 with push (C) and pop (B): count stays at 1.
        step();
        in_valid = 1'b0;
        check("bp_out_c", out_data, ref_shift(st_c, 0));
        check("bp_cnt1_valid", 128'(out_valid), 128'(1'b1));
        check("bp_cnt1_ready", 128'(in_ready), 128'(1'b1));
        step();
        check("bp_no_dup", 128'(out_valid), 128'(1'b0));

        // ---------------- streaming ----------------
        for (int i = 0; i < 16; i++)
            rnd[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = rnd[i];
            step();
            check($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'(1'b1));
            check($sformatf("stream_data_%0d", i), out_data, ref_shift(rnd[i], 0));
            check($sformatf("stream_ready_%0d", i), 128'(in_ready), 128'(1'b1));
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 128'(out_valid), 128'(1'b0));

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = st_a;
        step();
        in_data = st_b;
        step();
        in_valid = 1'b0;
        check("mid_full", 128'(in_ready), 128'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        check("mid_rst_data",  out_data, '0);
        check("mid_rst_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("mid_ready_after", 128'(in_ready), 128'(1'b1));
        check("mid_no_stale", 128'(out_valid), 128'(1'b0));
        step();
        check("mid_no_stale_2", 128'(out_valid), 128'(1'b0));
        check("mid_data_zero", out_data, '0);

`ifdef SHIFT_ROWS_INV_EN
        // ---------------- inverse mode ----------------
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_data  = VEC_OUT;
        step();
        check("inv_vector", out_data, VEC_IN);
        for (int i = 0; i < 6; i++) begin
            in_inv  = i[0];
            in_data = rnd[i];
            step();
            check($sformatf("mixed_mode_%0d", i), out_data, ref_shift(rnd[i], i[0]));
        end
        in_valid = 1'b0;
        in_inv   = 1'b0;
        step();
        check("inv_drained", 128'(out_valid), 128'(1'b0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_stage.md
# shift_rows_stage

Registered, flow-controlled AES ShiftRows stage for the encryption datapath, sitting between SubBytes and MixColumns. It applies the forward row rotation to a 128-bit state and buffers results in a 2-entry output queue, so upstream and downstream can stall independently without losing or duplicating a state. An optional build-time mode adds a per-transfer inverse select, which lets the same stage serve the decryption datapath.

## Interface
Parameters:
- none (state width is fixed at 128 bits; queue depth is fixed at 2)

Ports:
- clk  input  1  single clock for the whole block; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  in_data holds a state to transfer
- in_ready  output  1  stage can accept a state this cycle; registered
- in_data  input  128  input state; byte i is [127-8i -: 8], column-major, so byte 4c+r is row r, column c
- in_inv  input  1  present only with SHIFT_ROWS_INV_EN; 1 selects inverse ShiftRows for this transfer
- out_valid  output  1  out_data holds a transformed state
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  128  transformed state, same byte layout as in_data

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Forward transform: out[r][c] = in[r][(c+r) mod 4]. Row 0 is unchanged; rows 1, 2 and 3 rotate left by 1, 2 and 3 bytes.
  - Example: out byte 1 (out_data[119:112]) = in byte 5 (in_data[87:80]).
- Inverse transform (macro builds only, in_inv=1): out[r][c] = in[r][(c-r) mod 4].
  - Example: out byte 1 = in byte 13 (in_data[23:16]).
- The transform is applied before storage. The queue holds transformed states only.
- Queue: 2 entries, head pointer, tail pointer, and a 2-bit count (0..2).
  - Pointers are 1 bit each and wrap from 1 to 0.
  - out_data is always driven from the head entry. out_valid = (count != 0).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; head and tail both advance
  - neither: unchanged
- in_ready register next value = (next count < 2).
  - Ready does not depend combinationally on out_ready.
  - A pop while count is 2 raises in_ready on the following cycle.
- Entries are never overwritten while valid. Ordering is strictly FIFO.
- Reset (asynchronous, may occur mid-transfer):
  - count, head and tail go to 0, so out_valid=0.
  - in_ready=0.
  - All entries clear to 0, so out_data=0.
  - Any in-flight or held states are discarded.
- After reset release, in_ready rises on the first rising edge of clk.

## Timing
- Latency: a state pushed at edge k is visible on out_data with out_valid=1 after edge k, i.e. 1 cycle, when the queue was empty.
- Throughput: 1 state per cycle sustained while out_ready=1.
- out_valid/out_data stay stable while out_valid=1 and out_ready=0.
- Full queue (count=2): in_ready=0. in_valid is ignored.
- Empty queue: out_ready is ignored and no pop occurs.

## Configuration
- SHIFT_ROWS_INV_EN defined:
  - in_inv port exists.
  - Each transfer selects the forward or inverse transform independently; in_inv is sampled at push.
  - Back-to-back mixed modes are legal.
- SHIFT_ROWS_INV_EN undefined:
  - No in_inv port.
  - Forward transform only.
  - All other behaviour is identical.

## Test plan
- Reset and first transfer:
  - Stimulus: hold rst_n=0, then release. Push in_data=d42711aee0bf98f1b8b45de51e415230.
  - Required: out_valid=0, out_data=0 and in_ready=0 during reset; in_ready=1 one edge after release; one cycle after the push, out_data=d4bf5d30e0b452aeb84111f11e2798e5.
- Backpressure:
  - Stimulus: out_ready=0, push three states A, B, C on consecutive cycles.
  - Required: A and B are accepted; in_ready=0 after the second push; C is held upstream; out_data=shift(A) and stays stable.
  - Stimulus continued: raise out_ready.
  - Required: outputs appear in order A, B, C; no loss or duplication.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 16 random states.
  - Required: 16 outputs on consecutive cycles, each matching the reference-model ShiftRows, count never exceeds 1.
- Simultaneous push/pop at count 1 and at count 2:
  - Required at count 1: count unchanged and ordering preserved.
  - Required at count 2: only the pop occurs, and in_ready=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously with count=2 and out_ready=0.
  - Required: out_valid=0 and out_data=0 immediately; no stale state emerges after release.
- With SHIFT_ROWS_INV_EN:
  - Stimulus: push d4bf5d30e0b452aeb84111f11e2798e5 with in_inv=1.
  - Required: output d42711aee0bf98f1b8b45de51e415230.
  - Stimulus: alternate in_inv 0/1 on back-to-back transfers.
  - Required: each output uses its own mode.
